// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes the operands LSB first,
// one bit per clock, and publishes SUM/Cout/OVF together with a one-cycle done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             OVF
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load, step, last;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus datapath strobes; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + ~Cin, so Cout=1 means no borrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            SUM    <= '0;
            Cout   <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                opa   <= A;
                opb   <= SUB ? ~B : B;
                carry <= SUB ^ Cin;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (step) begin
                opa    <= opa >> 1;
                opb    <= opb >> 1;
                res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                carry  <= fa_co;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    // carry still holds the carry into the MSB here
                    SUM  <= {fa_s, res_sr[WIDTH-1:1]};
                    Cout <= fa_co;
                    OVF  <= carry ^ fa_co;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single fullAdder instance. It latches two WIDTH-bit operands on a start request and feeds the adder one bit per cycle, LSB first, through the carry register. It collects the sum bits and reports the result with a done pulse. The block serves area-constrained ALU paths where one 1-bit adder cell is reused instead of a WIDTH-bit ripple chain.

Parameters:
WIDTH, 32, operand and result width in bits (legal values 2..64).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin an operation; sampled only in IDLE or DONE.
SUB  input  1  0 = add, 1 = subtract; sampled together with start.
A  input  WIDTH  operand A; sampled together with start.
B  input  WIDTH  operand B; sampled together with start.
Cin  input  1  carry-in for add, borrow-in for subtract; sampled together with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when the result becomes valid.
SUM  output  WIDTH  registered result.
Cout  output  1  carry-out of the MSB; for subtract, 1 = no borrow.
OVF  output  1  signed overflow, equal to (carry into MSB) XOR Cout.

Behaviour:
- Reset, asserted asynchronously at any time, including mid-operation:
  - state = IDLE.
  - busy, done, SUM, Cout, OVF, bit counter, shift registers and carry register all = 0.
- State machine:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit cycles.
  - DONE -> IDLE if start=0.
  - DONE -> RUN if start=1, so back-to-back operations are allowed.
- Load, on the accepting edge E0:
  - Opa <= A.
  - Opb <= SUB ? ~B : B.
  - carry <= SUB ? ~Cin : Cin.
  - counter <= 0.
  - busy <= 1.
  - Result: add computes A+B+Cin; subtract computes A-B-Cin.
- RUN, edges E1..EWIDTH, one bit per edge:
  - fullAdder inputs are Opa[0], Opb[0] and carry.
  - Sum bit shifts into the MSB of the internal result shift register.
  - Opa and Opb shift right by one.
  - carry <= adder Cout.
  - counter increments.
  - On the edge processing bit WIDTH-1, the carry-in of that bit is captured for OVF.
- Edge EWIDTH:
  - SUM, Cout and OVF update from the internal registers.
  - state = DONE, done = 1, busy = 0.
- Latency: result valid and done high in the cycle following edge EWIDTH, i.e. WIDTH+1 edges after start is sampled.
- done is high for exactly one cycle unless a new start is accepted in DONE. In that case done drops on the next edge and busy rises.
- start while busy: ignored. Operands, SUB and Cin changing while busy: no effect.
- SUM, Cout and OVF hold their last values until the next completion or reset. They never show partial results.
- Counter width is ceil(log2(WIDTH))+1 bits and does not wrap during RUN.

Test Plan:
- WIDTH=8, A=0x7F, B=0x01, Cin=0, SUB=0, start for 1 cycle -> done exactly 9 edges after the start edge; SUM=0x80, Cout=0, OVF=1; busy high for 8 cycles.
- WIDTH=8, A=0xFF, B=0x01, Cin=0, add -> SUM=0x00, Cout=1, OVF=0.
- WIDTH=8, SUB=1, A=0x05, B=0x07, Cin=0 -> SUM=0xFE, Cout=0 (borrow), OVF=0. Repeat with A=0x80, B=0x01 -> SUM=0x7F, Cout=1, OVF=1.
- Pulse start again at bit 3 of a run with different operands -> ignored; result equals the first operation. Hold start high through DONE -> second operation starts immediately and done pulses once per operation.
- Assert reset asynchronously mid-run after 3 bits -> all outputs 0 immediately, without waiting for a clock edge. After release, a new start of 0x12+0x34 -> SUM=0x46.
- WIDTH=4, exhaustive sweep of A, B, Cin and SUB (1024 cases) against a behavioural model -> SUM, Cout and OVF all match, and done fires every 5 edges.
